inst_encoder: RTL and testbench

- Pipelined RV32I instruction encoder: accepts a DecodedInst and emits the 32-bit instruction word that the decoder would map back to it.
- Used by the on-chip program loader and the CPU self-test bench to build instruction memory images from structured instructions.
- Valid/ready streaming on both sides, 2-cycle latency, full throughput, and a per-word error flag for unencodable input.

---
 rtl/inst_encoder_if.sv | 41 ++++
 rtl/inst_encoder.sv | 250 +++++++++++++++++++++++++
 tb/tb_inst_encoder.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_encoder_if.sv
// Streaming interface for the RV32I instruction encoder: structured
// instruction in, encoded 32-bit word plus error flag out.
//
// Field encodings of the decoded instruction:
//   itype  : 0 Unsupported, 1 LUI, 2 AUIPC, 3 JAL, 4 JALR, 5 BRANCH,
//            6 LOAD, 7 STORE, 8 OPIMM, 9 OP, others unknown
//   alufunc: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL,
//            8 SRL, 9 SRA
//   brfunc : 0 EQ, 1 NEQ, 2 LT, 3 GE, 4 LTU, 5 GEU
//   memfunc: 0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 SW, 6 SH, 7 SB
interface inst_encoder_if;
  typedef struct packed {
    logic [3:0]  itype;
    logic [3:0]  alufunc;
    logic [2:0]  brfunc;
    logic [2:0]  memfunc;
    logic [4:0]  dst;
    logic        dst_valid;
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic [31:0] imm;
  } decoded_inst_t;

  logic          in_valid;
  logic          in_ready;
  decoded_inst_t dinst_in;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   inst_out;
  logic          err_out;

  modport slave (
    input  in_valid, dinst_in, out_ready,
    output in_ready, out_valid, inst_out, err_out
  );

  modport master (
    output in_valid, dinst_in, out_ready,
    input  in_ready, out_valid, inst_out, err_out
  );
endinterface

// File: rtl/inst_encoder.sv
// Two-stage RV32I instruction encoder. S1 decodes the structured
// instruction into raw fields plus a packed immediate and an error bit;
// S2 places those fields into the final word (NOP on error).
module inst_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  inst_encoder_if.slave    bus,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  // Stage S1 registers
  logic        s1_valid_q;
  logic [6:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [2:0]  f3_q, f3_d;
  logic [6:0]  f7_q, f7_d;
  logic [19:0] imm_q, imm_d;
  logic        err1_q, err1_d;

  // Stage S2 (output) registers
  logic             s2_valid_q;
  logic [31:0]      inst_q, inst_d;
  logic             err_q;
  logic [CNT_W-1:0] enc_cnt_q, err_cnt_q;

  logic s2_ready, s1_ready, accept, advance, emit;
  logic [31:0] imm;
  logic i_ok, b_ok, j_ok;
  logic [2:0] alu_f3;
  logic alu_bad, alu_shift, alu_alt;

  assign s2_ready = !s2_valid_q || bus.out_ready;
  assign s1_ready = !s1_valid_q || s2_ready;
  assign accept   = bus.in_valid && s1_ready;
  assign advance  = s1_valid_q && s2_ready;
  assign emit     = s2_valid_q && bus.out_ready;

  assign bus.in_ready  = s1_ready;
  assign bus.out_valid = s2_valid_q;
  assign bus.inst_out  = inst_q;
  assign bus.err_out   = err_q;
  assign enc_count     = enc_cnt_q;
  assign err_count     = err_cnt_q;

  // Immediate range checks: upper bits must be pure sign extension
  assign imm  = bus.dinst_in.imm;
  assign i_ok = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign b_ok = ((imm[31:12] == '0) || (imm[31:12] == '1)) && !imm[0];
  assign j_ok = ((imm[31:20] == '0) || (imm[31:20] == '1)) && !imm[0];

  // ALU function to funct3, shift/alternate flags
  always_comb begin
    alu_f3    = 3'b000;
    alu_bad   = 1'b0;
    alu_shift = 1'b0;
    alu_alt   = 1'b0;
    case (bus.dinst_in.alufunc)
      4'd0: alu_f3 = 3'b000;
      4'd1: begin alu_f3 = 3'b000; alu_alt = 1'b1; end
      4'd2: alu_f3 = 3'b111;
      4'd3: alu_f3 = 3'b110;
      4'd4: alu_f3 = 3'b100;
      4'd5: alu_f3 = 3'b010;
      4'd6: alu_f3 = 3'b011;
      4'd7: begin alu_f3 = 3'b001; alu_shift = 1'b1; end
      4'd8: begin alu_f3 = 3'b101; alu_shift = 1'b1; end
      4'd9: begin alu_f3 = 3'b101; alu_shift = 1'b1; alu_alt = 1'b1; end
      default: alu_bad = 1'b1;
    endcase
  end

  // S1 decode: raw fields, packed immediate and the error bit
  always_comb begin
    op_d   = OP_OPIMM;
    rd_d   = bus.dinst_in.dst_valid ? bus.dinst_in.dst : 5'd0;
    rs1_d  = 5'd0;
    rs2_d  = 5'd0;
    f3_d   = 3'b000;
    f7_d   = 7'd0;
    imm_d  = 20'd0;
    err1_d = 1'b0;
    case (bus.dinst_in.itype)
      4'd1, 4'd2: begin
        op_d   = (bus.dinst_in.itype == 4'd1) ? OP_LUI : OP_AUIPC;
        imm_d  = imm[31:12];
        err1_d = (imm[11:0] != 12'd0);
      end
      4'd3: begin
        op_d   = OP_JAL;
        imm_d  = {imm[20], imm[10:1], imm[11], imm[19:12]};
        err1_d = !j_ok;
      end
      4'd4: begin
        op_d   = OP_JALR;
        rs1_d  = bus.dinst_in.src1;
        imm_d  = {8'd0, imm[11:0]};
        err1_d = !i_ok;
      end
      4'd5: begin
        op_d  = OP_BRANCH;
        rd_d  = 5'd0;
        rs1_d = bus.dinst_in.src1;
        rs2_d = bus.dinst_in.src2;
        imm_d = {8'd0, imm[12], imm[10:5], imm[4:1], imm[11]};
        case (bus.dinst_in.brfunc)
          3'd0: f3_d = 3'b000;
          3'd1: f3_d = 3'b001;
          3'd2: f3_d = 3'b100;
          3'd3: f3_d = 3'b101;
          3'd4: f3_d = 3'b110;
          3'd5: f3_d = 3'b111;
          default: err1_d = 1'b1;
        endcase
        if (!b_ok) err1_d = 1'b1;
      end
      4'd6: begin
        op_d   = OP_LOAD;
        rs1_d  = bus.dinst_in.src1;
        imm_d  = {8'd0, imm[11:0]};
        err1_d = !i_ok;
        case (bus.dinst_in.memfunc)
          3'd0: f3_d = 3'b010;
          3'd1: f3_d = 3'b001;
          3'd2: f3_d = 3'b101;
          3'd3: f3_d = 3'b000;
          3'd4: f3_d = 3'b100;
          default: err1_d = 1'b1;
        endcase
      end
      4'd7: begin
        op_d   = OP_STORE;
        rd_d   = 5'd0;
        rs1_d  = bus.dinst_in.src1;
        rs2_d  = bus.dinst_in.src2;
        imm_d  = {8'd0, imm[11:0]};
        err1_d = !i_ok;
        case (bus.dinst_in.memfunc)
          3'd5: f3_d = 3'b010;
          3'd6: f3_d = 3'b001;
          3'd7: f3_d = 3'b000;
          default: err1_d = 1'b1;
        endcase
      end
      4'd8: begin
        op_d  = OP_OPIMM;
        rs1_d = bus.dinst_in.src1;
        f3_d  = alu_f3;
        if (alu_shift) begin
          f7_d   = alu_alt ? F7_ALT : 7'd0;
          imm_d  = {8'd0, f7_d, imm[4:0]};
          err1_d = (imm[31:5] != 27'd0);
        end else begin
          imm_d  = {8'd0, imm[11:0]};
          err1_d = !i_ok || alu_alt;
        end
        if (alu_bad) err1_d = 1'b1;
      end
      4'd9: begin
        op_d   = OP_OP;
        rs1_d  = bus.dinst_in.src1;
        rs2_d  = bus.dinst_in.src2;
        f3_d   = alu_f3;
        f7_d   = alu_alt ? F7_ALT : 7'd0;
        err1_d = alu_bad;
      end
      default: err1_d = 1'b1;
    endcase
  end

  // S2 assembly: place S1 fields by instruction format
  always_comb begin
    case (op_q)
      OP_LUI, OP_AUIPC, OP_JAL:
        inst_d = {imm_q, rd_q, op_q};
      OP_JALR, OP_LOAD, OP_OPIMM:
        inst_d = {imm_q[11:0], rs1_q, f3_q, rd_q, op_q};
      OP_BRANCH, OP_STORE:
        inst_d = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], op_q};
      default:
        inst_d = {f7_q, rs2_q, rs1_q, f3_q, rd_q, op_q};
    endcase
    if (err1_q) inst_d = NOP;
  end

  // S1 register: load on accept, empty when the word moves to S2
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_valid_q <= 1'b0;
      op_q       <= 7'd0;
      rd_q       <= 5'd0;
      rs1_q      <= 5'd0;
      rs2_q      <= 5'd0;
      f3_q       <= 3'd0;
      f7_q       <= 7'd0;
      imm_q      <= 20'd0;
      err1_q     <= 1'b0;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
      op_q       <= op_d;
      rd_q       <= rd_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      f3_q       <= f3_d;
      f7_q       <= f7_d;
      imm_q      <= imm_d;
      err1_q     <= err1_d;
    end else if (advance) begin
      s1_valid_q <= 1'b0;
    end
  end

  // S2 output register and emitted-word counters
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s2_valid_q <= 1'b0;
      inst_q     <= 32'd0;
      err_q      <= 1'b0;
      enc_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (s2_ready) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          inst_q <= inst_d;
          err_q  <= err1_q;
        end
      end
      if (emit) begin
        if (err_q) err_cnt_q <= err_cnt_q + 1'b1;
        else       enc_cnt_q <= enc_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: directed vectors with hand-computed
// words are pushed on accept; a negedge monitor pops and compares.
module tb_inst_encoder;

  localparam int CNT_W = 16;

  typedef struct {
    logic [3:0]  it;
    logic [3:0]  alu;
    logic [2:0]  br;
    logic [2:0]  mem;
    logic [4:0]  dst;
    logic        dv;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [31:0] imm;
    logic        err;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] inst;
  } exp_t;

  localparam int NV = 21;

  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  logic [CNT_W-1:0] enc_count, err_count;

  inst_encoder_if bus ();

  inst_encoder #(.CNT_W(CNT_W)) dut (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .bus       (bus),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  always #5 clk_in = ~clk_in;

  vec_t tbl [NV];
  exp_t sb_q [$];
  int   n_vec = 0;
  int   n_fail = 0;
  int   m_enc = 0;
  int   m_err = 0;
  logic rnd_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] it, input logic [3:0] alu, input logic [2:0] br,
                              input logic [2:0] mem, input logic [4:0] dst, input logic dv,
                              input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] imm,
                              input logic err, input logic [31:0] exp);
    vec_t v;
    v.it = it; v.alu = alu; v.br = br; v.mem = mem; v.dst = dst; v.dv = dv;
    v.s1 = s1; v.s2 = s2; v.imm = imm; v.err = err; v.exp = exp;
    return v;
  endfunction

  // Monitor: compare every output transfer against the scoreboard
  always @(negedge clk_in) begin
    if (!rst_n_in) begin
      sb_q.delete();
      m_enc = 0;
      m_err = 0;
    end else if (bus.out_valid && bus.out_ready) begin
      check("enc_count", 32'(enc_count), 32'(m_enc[CNT_W-1:0]));
      check("err_count", 32'(err_count), 32'(m_err[CNT_W-1:0]));
      if (sb_q.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("inst_out", bus.inst_out, e.inst);
        check("err_out", 32'(bus.err_out), 32'(e.err));
        if (e.err) m_err++;
        else       m_enc++;
      end
    end
  end

  // Random out_ready while rnd_mode is set
  initial begin
    forever begin
      @(posedge clk_in);
      #1;
      if (rnd_mode) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Present one vector; called and returns at posedge+1
  task automatic send(input int idx, output int stalls);
    vec_t v;
    v = tbl[idx];
    stalls = 0;
    bus.dinst_in.itype     = v.it;
    bus.dinst_in.alufunc   = v.alu;
    bus.dinst_in.brfunc    = v.br;
    bus.dinst_in.memfunc   = v.mem;
    bus.dinst_in.dst       = v.dst;
    bus.dinst_in.dst_valid = v.dv;
    bus.dinst_in.src1      = v.s1;
    bus.dinst_in.src2      = v.s2;
    bus.dinst_in.imm       = v.imm;
    bus.in_valid = 1'b1;
    forever begin
      @(negedge clk_in);
      if (bus.in_ready) begin
        sb_q.push_back('{err: v.err, inst: v.exp});
        break;
      end
      check("stall_only_when_full", 32'(bus.out_valid && !bus.out_ready), 32'd1);
      stalls++;
      if (stalls > 1000) begin
        check("in_ready_timeout", 32'd0, 32'd1);
        break;
      end
      @(posedge clk_in);
    end
    @(posedge clk_in);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 3000) begin
      @(posedge clk_in);
      guard++;
    end
    if (guard >= 3000) check("drain_timeout", 32'(sb_q.size()), 32'd0);
    repeat (2) @(posedge clk_in);
    #1;
  endtask

  initial begin
    int st, tot;
    tbl[0]  = mk(4'd8, 4'd0, 3'd0, 3'd0, 5'd1, 1'b1, 5'd2, 5'd0, 32'd5,          1'b0, 32'h0051_0093);
    tbl[1]  = mk(4'd1, 4'd0, 3'd0, 3'd0, 5'd5, 1'b1, 5'd0, 5'd0, 32'h1234_5000,  1'b0, 32'h1234_52B7);
    tbl[2]  = mk(4'd7, 4'd0, 3'd0, 3'd5, 5'd0, 1'b0, 5'd2, 5'd3, 32'hFFFF_FFFC,  1'b0, 32'hFE31_2E23);
    tbl[3]  = mk(4'd5, 4'd0, 3'd0, 3'd0, 5'd0, 1'b0, 5'd1, 5'd2, 32'd8,          1'b0, 32'h0020_8463);
    tbl[4]  = mk(4'd3, 4'd0, 3'd0, 3'd0, 5'd1, 1'b1, 5'd0, 5'd0, 32'd2048,       1'b0, 32'h0010_00EF);
    tbl[5]  = mk(4'd8, 4'd0, 3'd0, 3'd0, 5'd1, 1'b1, 5'd2, 5'd0, 32'd4096,       1'b1, 32'h0000_0013);
    tbl[6]  = mk(4'd5, 4'd0, 3'd0, 3'd0, 5'd0, 1'b0, 5'd1, 5'd2, 32'd3,          1'b1, 32'h0000_0013);
    tbl[7]  = mk(4'd9, 4'd1, 3'd0, 3'd0, 5'd3, 1'b1, 5'd1, 5'd2, 32'd0,          1'b0, 32'h4020_81B3);
    tbl[8]  = mk(4'd8, 4'd9, 3'd0, 3'd0, 5'd4, 1'b1, 5'd5, 5'd0, 32'd3,          1'b0, 32'h4032_D213);
    tbl[9]  = mk(4'd6, 4'd0, 3'd0, 3'd0, 5'd6, 1'b1, 5'd7, 5'd0, 32'hFFFF_FFFF,  1'b0, 32'hFFF3_A303);
    tbl[10] = mk(4'd4, 4'd0, 3'd0, 3'd0, 5'd1, 1'b1, 5'd1, 5'd0, 32'd0,          1'b0, 32'h0000_80E7);
    tbl[11] = mk(4'd2, 4'd0, 3'd0, 3'd0, 5'd10, 1'b1, 5'd0, 5'd0, 32'h0000_1000, 1'b0, 32'h0000_1517);
    tbl[12] = mk(4'd9, 4'd0, 3'd0, 3'd0, 5'd9, 1'b0, 5'd1, 5'd2, 32'd0,          1'b0, 32'h0020_8033);
    tbl[13] = mk(4'd6, 4'd0, 3'd0, 3'd5, 5'd6, 1'b1, 5'd7, 5'd0, 32'd0,          1'b1, 32'h0000_0013);
    tbl[14] = mk(4'd1, 4'd0, 3'd0, 3'd0, 5'd5, 1'b1, 5'd0, 5'd0, 32'h1234_5001,  1'b1, 32'h0000_0013);
    tbl[15] = mk(4'd0, 4'd0, 3'd0, 3'd0, 5'd1, 1'b1, 5'd0, 5'd0, 32'd0,          1'b1, 32'h0000_0013);
    tbl[16] = mk(4'd8, 4'd7, 3'd0, 3'd0, 5'd1, 1'b1, 5'd1, 5'd0, 32'd32,         1'b1, 32'h0000_0013);
    tbl[17] = mk(4'd5, 4'd0, 3'd1, 3'd0, 5'd0, 1'b0, 5'd0, 5'd0, 32'hFFFF_FFFE,  1'b0, 32'hFE00_1FE3);
    tbl[18] = mk(4'd7, 4'd0, 3'd0, 3'd7, 5'd0, 1'b0, 5'd1, 5'd2, 32'd2047,       1'b0, 32'h7E20_8FA3);
    tbl[19] = mk(4'd3, 4'd0, 3'd0, 3'd0, 5'd1, 1'b1, 5'd0, 5'd0, 32'h0010_0000,  1'b1, 32'h0000_0013);
    tbl[20] = mk(4'd8, 4'd1, 3'd0, 3'd0, 5'd1, 1'b1, 5'd1, 5'd0, 32'd1,          1'b1, 32'h0000_0013);

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.dinst_in  = '0;

    // Reset state
    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_inst_out", bus.inst_out, 32'd0);
    check("rst_enc_count", 32'(enc_count), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
    check("in_ready_after_reset", 32'(bus.in_ready), 32'd1);

    // Latency of the first word: visible after the second edge
    send(0, st);
    check("latency_s1", 32'(bus.out_valid), 32'd0);
    @(posedge clk_in);
    #1;
    check("latency_s2", 32'(bus.out_valid), 32'd1);
    drain();
    check("enc_count_first", 32'(enc_count), 32'd1);

    // Directed vectors back-to-back at out_ready=1: no stalls
    tot = 0;
    for (int i = 1; i < NV; i++) begin
      send(i, st);
      tot += st;
    end
    check("full_throughput_stalls", 32'(tot), 32'd0);
    drain();

    // 100 words with random backpressure
    rnd_mode = 1'b1;
    for (int i = 0; i < 100; i++) send(int'($urandom_range(0, NV - 1)), st);
    rnd_mode = 1'b0;
    @(posedge clk_in);
    #1;
    bus.out_ready = 1'b1;
    drain();
    check("final_enc_count", 32'(enc_count), 32'(m_enc[CNT_W-1:0]));
    check("final_err_count", 32'(err_count), 32'(m_err[CNT_W-1:0]));

    // Reset with both stages full
    bus.out_ready = 1'b0;
    send(1, st);
    send(2, st);
    check("both_full_in_ready", 32'(bus.in_ready), 32'd0);
    #2;
    rst_n_in = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_inst_out", bus.inst_out, 32'd0);
    check("midrst_enc_count", 32'(enc_count), 32'd0);
    check("midrst_err_count", 32'(err_count), 32'd0);
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk_in);
    #1;
    check("in_ready_after_midrst", 32'(bus.in_ready), 32'd1);
    send(3, st);
    check("post_rst_latency_s1", 32'(bus.out_valid), 32'd0);
    @(posedge clk_in);
    #1;
    check("post_rst_latency_s2", 32'(bus.out_valid), 32'd1);
    drain();
    check("post_rst_enc_count", 32'(enc_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
